seq_playback: RTL

- Parametrised successor to the 4-note-wide challenge playback engine.
- Latches a level of up to MAX_NOTES notes of NOTE_W bits each, then plays them in order on start.
- Each note is held for a runtime-programmable number of clock cycles.
- Sits between level ROM/loader and the note-display/tone logic; signals completion to the game-control FSM with a one-cycle done pulse and a busy level.

---
 rtl/seq_playback_pkg.sv | 21 ++
 rtl/seq_duration_counter.sv | 22 ++
 rtl/seq_playback.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seq_playback_pkg.sv
// Shared types, default parameters and helpers for the seq_playback note sequencer.
package seq_playback_pkg;

  localparam int DEF_NOTE_W    = 4;
  localparam int DEF_MAX_NOTES = 8;
  localparam int DEF_LEN_W     = 4;
  localparam int DEF_CNT_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    PLAY   = 2'd2,
    GAP    = 2'd3
  } state_t;

  // Requested level length saturated to the number of physical slots.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_notes);
    return (len > max_notes) ? max_notes : len;
  endfunction

endpackage

// File: rtl/seq_duration_counter.sv
// Loadable down-counter that parks at zero; shared by note and gap timing.
module seq_duration_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_playback.sv
// Level playback engine: latches up to MAX_NOTES notes and plays them with a programmable hold time.
// Define SEQ_PLAYBACK_GAP_EN to add a gap_period input and silent GAP cycles between notes.
module seq_playback
  import seq_playback_pkg::*;
#(
  parameter int NOTE_W    = DEF_NOTE_W,
  parameter int MAX_NOTES = DEF_MAX_NOTES,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NOTE_W*MAX_NOTES-1:0] level_data,
  input  logic [LEN_W-1:0]            level_length,
  input  logic [CNT_W-1:0]            note_period,
`ifdef SEQ_PLAYBACK_GAP_EN
  input  logic [CNT_W-1:0]            gap_period,
`endif
  input  logic                        load_level,
  input  logic                        start_playback,
  input  logic                        stop,
  output logic [NOTE_W-1:0]           note_out,
  output logic                        note_valid,
  output logic [LEN_W-1:0]            note_index,
  output logic                        busy,
  output logic                        done_playback
);

  state_t                      state, state_nx;
  logic [NOTE_W*MAX_NOTES-1:0] level_r;
  logic [LEN_W-1:0]            length_r, index_r, idx_nx;
  logic [CNT_W-1:0]            period_r, start_period, cnt_val;
  logic                        done_r, done_nx;
  logic                        do_load, do_start, cnt_load, cnt_zero, last;
  logic [NOTE_W-1:0]           note_sel;
`ifdef SEQ_PLAYBACK_GAP_EN
  logic [CNT_W-1:0]            gap_r;
`endif

  assign start_period = (note_period == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : note_period;
  assign last         = ((index_r + 1'b1) == length_r);

  seq_duration_counter #(.CNT_W(CNT_W)) u_dur (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = index_r;
    done_nx  = 1'b0;
    do_load  = 1'b0;
    do_start = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE: begin
        if (load_level) begin
          do_load  = 1'b1;
          state_nx = LOADED;
        end
      end
      LOADED: begin
        // A load in the same cycle as a start takes precedence; the start is dropped.
        if (load_level) begin
          do_load = 1'b1;
        end else if (start_playback) begin
          do_start = 1'b1;
          if (length_r == '0) begin
            done_nx = 1'b1;
          end else begin
            state_nx = PLAY;
            idx_nx   = '0;
            cnt_load = 1'b1;
            cnt_val  = start_period - 1'b1;
          end
        end
      end
      PLAY: begin
        if (stop) begin
          state_nx = LOADED;
          idx_nx   = '0;
        end else if (cnt_zero) begin
          if (last) begin
            state_nx = LOADED;
            idx_nx   = '0;
            done_nx  = 1'b1;
          end
`ifdef SEQ_PLAYBACK_GAP_EN
          else if (gap_r != '0) begin
            state_nx = GAP;
            cnt_load = 1'b1;
            cnt_val  = gap_r - 1'b1;
          end
`endif
          else begin
            idx_nx   = index_r + 1'b1;
            cnt_load = 1'b1;
            cnt_val  = period_r - 1'b1;
          end
        end
      end
`ifdef SEQ_PLAYBACK_GAP_EN
      GAP: begin
        if (stop) begin
          state_nx = LOADED;
          idx_nx   = '0;
        end else if (cnt_zero) begin
          state_nx = PLAY;
          idx_nx   = index_r + 1'b1;
          cnt_load = 1'b1;
          cnt_val  = period_r - 1'b1;
        end
      end
`endif
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      level_r  <= '0;
      length_r <= '0;
      index_r  <= '0;
      period_r <= '0;
      done_r   <= 1'b0;
`ifdef SEQ_PLAYBACK_GAP_EN
      gap_r    <= '0;
`endif
    end else begin
      state   <= state_nx;
      index_r <= idx_nx;
      done_r  <= done_nx;
      if (do_load) begin
        level_r  <= level_data;
        length_r <= LEN_W'(clamp_len(32'(level_length), MAX_NOTES));
      end
      if (do_start) begin
        period_r <= start_period;
`ifdef SEQ_PLAYBACK_GAP_EN
        gap_r    <= gap_period;
`endif
      end
    end
  end

  // Note 0 occupies the most significant slot of the packed level.
  always_comb begin
    note_sel = '0;
    for (int i = 0; i < MAX_NOTES; i++)
      if (index_r == LEN_W'(i)) note_sel = level_r[(MAX_NOTES-1-i)*NOTE_W +: NOTE_W];
  end

  assign note_valid    = (state == PLAY);
  assign busy          = (state == PLAY) || (state == GAP);
  assign note_out      = note_valid ? note_sel : '0;
  assign note_index    = busy ? index_r : '0;
  assign done_playback = done_r;

endmodule
